// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution stage feeding the program counter.
//
// Holds the registered ALU flags {N,C,Z}, a loadable table of relative
// branch offsets (2**LW entries of TW+1 bits) and a run/halt FSM. Each
// cycle it tells the PC whether to take a relative jump, by how much, and
// in which direction. Done is high while the program is halted.
//
// Ports:
//   Clk, Reset                - clock, synchronous active-high reset
//   Start                     - program (re)start request
//   Going                     - PC is ticking; qualifies the instruction
//   BrOp[2:0]                 - decoded branch op
//   LutIdx[LW-1:0]            - offset-table index of the instruction
//   FlagWrEn, AluZero/Neg/Carry - flag latch strobe and ALU flags
//   LutWrEn, LutWrAddr, LutWrData - table write port ({dir, magnitude})
//   BranchRelEn, Target, Forward  - relative-jump request to the PC
//   Flags[2:0]                - registered {N,C,Z}
//   Done                      - high while HALTED
//   TakenCount[15:0]          - saturating taken-branch count (optional)
//
// Optional feature: define BRANCH_STATS_EN to add TakenCount.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for the PC to start ticking
// RUN     | program executing, branches evaluated
// HALTED  | HALT retired, Done high until Start

module branch_ctrl #(
  parameter int LW = 4,
  parameter int TW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Going,
  input  logic [2:0]    BrOp,
  input  logic [LW-1:0] LutIdx,
  input  logic          FlagWrEn,
  input  logic          AluZero,
  input  logic          AluNeg,
  input  logic          AluCarry,
  input  logic          LutWrEn,
  input  logic [LW-1:0] LutWrAddr,
  input  logic [TW:0]   LutWrData,
  output logic          BranchRelEn,
  output logic [TW-1:0] Target,
  output logic          Forward,
  output logic [2:0]    Flags,
  output logic          Done
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]   TakenCount
`endif
);

  localparam int DEPTH = 1 << LW;

  localparam logic [2:0] OP_ALWAYS = 3'b001;
  localparam logic [2:0] OP_BEQ    = 3'b010;
  localparam logic [2:0] OP_BNE    = 3'b011;
  localparam logic [2:0] OP_BLT    = 3'b100;
  localparam logic [2:0] OP_BCS    = 3'b101;
  localparam logic [2:0] OP_HALT   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  flags_q;   // {N,C,Z}
  logic        done_q;
  logic [TW:0] lut_q [DEPTH];
  logic [TW:0] entry;
  logic        cond;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Going) state_d = S_RUN;
      S_RUN: begin
        // restart wins over a HALT in the same cycle
        if (Start)                         state_d = S_IDLE;
        else if (Going && BrOp == OP_HALT) state_d = S_HALTED;
      end
      S_HALTED: if (Start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_HALTED);
      if (Start)
        flags_q <= '0;
      else if (FlagWrEn && state_q == S_RUN)
        flags_q <= {AluNeg, AluCarry, AluZero};
      if (LutWrEn) lut_q[LutWrAddr] <= LutWrData;
    end
  end

  // Read uses the registered table and flags, so same-cycle writes are
  // seen one cycle later.
  assign entry   = lut_q[LutIdx];
  assign Target  = entry[TW-1:0];
  assign Forward = entry[TW];

  always_comb begin
    cond = 1'b0;
    case (BrOp)
      OP_ALWAYS: cond = 1'b1;
      OP_BEQ:    cond = flags_q[0];
      OP_BNE:    cond = ~flags_q[0];
      OP_BLT:    cond = flags_q[2];
      OP_BCS:    cond = flags_q[1];
      default:   cond = 1'b0;
    endcase
  end

  // A zero-magnitude jump is dropped so the PC falls through instead of
  // spinning on the same instruction.
  assign BranchRelEn = (state_q == S_RUN) && Going && cond && (entry[TW-1:0] != '0);
  assign Flags       = flags_q;
  assign Done        = done_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset || Start)
      taken_cnt_q <= '0;
    else if (BranchRelEn && taken_cnt_q != 16'hFFFF)
      taken_cnt_q <= taken_cnt_q + 16'd1;
  end

  assign TakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the branch stage.
module tb_branch_ctrl;

  localparam int LW = 4;
  localparam int TW = 8;

  logic          Clk = 1'b0;
  logic          Reset, Start, Going, FlagWrEn, AluZero, AluNeg, AluCarry, LutWrEn;
  logic [2:0]    BrOp;
  logic [LW-1:0] LutIdx, LutWrAddr;
  logic [TW:0]   LutWrData;
  logic          BranchRelEn, Forward, Done;
  logic [TW-1:0] Target;
  logic [2:0]    Flags;
`ifdef BRANCH_STATS_EN
  logic [15:0]   TakenCount;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model: 0 idle, 1 run, 2 halted
  int          m_st;
  bit          m_n, m_c, m_z;
  logic [TW:0] m_tab [16];
  int          m_cnt;

  branch_ctrl #(.LW(LW), .TW(TW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Going(Going), .BrOp(BrOp),
    .LutIdx(LutIdx), .FlagWrEn(FlagWrEn), .AluZero(AluZero), .AluNeg(AluNeg),
    .AluCarry(AluCarry), .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr),
    .LutWrData(LutWrData), .BranchRelEn(BranchRelEn), .Target(Target),
    .Forward(Forward), .Flags(Flags), .Done(Done)
`ifdef BRANCH_STATS_EN
    , .TakenCount(TakenCount)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic bit m_taken();
    bit c;
    int mag;
    mag = int'(m_tab[LutIdx][TW-1:0]);
    case (BrOp)
      3'd1:    c = 1;
      3'd2:    c = m_z;
      3'd3:    c = !m_z;
      3'd4:    c = m_n;
      3'd5:    c = m_c;
      default: c = 0;
    endcase
    return (m_st == 1) && Going && c && (mag > 0);
  endfunction

  // Advance one clock and update the model with the inputs held this cycle.
  task automatic cycle();
    bit tk;
    tk = m_taken();
    @(posedge Clk);
    if (Reset) begin
      m_st = 0; m_n = 0; m_c = 0; m_z = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_tab[i] = '0;
    end else begin
      if (Start) begin
        m_n = 0; m_c = 0; m_z = 0; m_cnt = 0;
      end else begin
        if (FlagWrEn && m_st == 1) begin
          m_n = AluNeg; m_c = AluCarry; m_z = AluZero;
        end
        if (tk && m_cnt < 65535) m_cnt++;
      end
      if (LutWrEn) m_tab[LutWrAddr] = LutWrData;
      if (m_st == 0) begin
        if (Going) m_st = 1;
      end else if (Start) m_st = 0;
      else if (m_st == 1 && Going && BrOp == 3'b110) m_st = 2;
    end
    #1;
  endtask

  task automatic quiet();
    Reset = 0; Start = 0; Going = 0; BrOp = 0; LutIdx = 0; FlagWrEn = 0;
    AluZero = 0; AluNeg = 0; AluCarry = 0; LutWrEn = 0; LutWrAddr = 0; LutWrData = 0;
  endtask

  task automatic test_reset();
    quiet();
    Reset = 1;
    cycle(); cycle();
    #2;
    checks++;
    if ({BranchRelEn, Target, Forward, Flags, Done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rel=%b tgt=%h fwd=%b flags=%b done=%b, want all zero",
               BranchRelEn, Target, Forward, Flags, Done);
    end
    Reset = 0;
  endtask

  task automatic test_run_entry();
    Start = 1;
    cycle();
    Start = 0; Going = 1; BrOp = 3'b001;
    #2;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL idle_no_branch: got %b want 0", BranchRelEn);
    end
    BrOp = 0;
    cycle();
    #2;
    checks++;
    if ({BranchRelEn, Flags, Done} !== 5'b0) begin
      errors++;
      $display("FAIL run_entry: got rel=%b flags=%b done=%b want 0/000/0", BranchRelEn, Flags, Done);
    end
  endtask

  task automatic test_always();
    LutWrEn = 1; LutWrAddr = 3; LutWrData = 9'h105;
    cycle();
    LutWrEn = 0; BrOp = 3'b001; LutIdx = 3;
    #2;
    checks++;
    if ({BranchRelEn, Target, Forward} !== {1'b1, 8'h05, 1'b1}) begin
      errors++;
      $display("FAIL always_taken: got rel=%b tgt=%h fwd=%b want 1/05/1", BranchRelEn, Target, Forward);
    end
    Going = 0;
    #1;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL not_going: got %b want 0", BranchRelEn);
    end
    Going = 1;
  endtask

  task automatic test_flag_timing();
    BrOp = 3'b010; LutIdx = 3; FlagWrEn = 1; AluZero = 1;
    #2;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL beq_old_flags: got %b want 0", BranchRelEn);
    end
    cycle();
    FlagWrEn = 0; AluZero = 0;
    #2;
    checks++;
    if ({BranchRelEn, Flags} !== 4'b1001) begin
      errors++; $display("FAIL beq_new_flags: got rel=%b flags=%b want 1/001", BranchRelEn, Flags);
    end
    BrOp = 3'b011;
    #1;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL bne_z1: got %b want 0", BranchRelEn);
    end
  endtask

  task automatic test_blt();
    LutWrEn = 1; LutWrAddr = 2; LutWrData = 9'h003;
    BrOp = 3'b100; LutIdx = 2; FlagWrEn = 1;
    cycle();
    LutWrEn = 0;
    #2;
    checks++;
    if ({BranchRelEn, Target, Flags} !== {1'b0, 8'h03, 3'b000}) begin
      errors++;
      $display("FAIL blt_n0: got rel=%b tgt=%h flags=%b want 0/03/000", BranchRelEn, Target, Flags);
    end
    AluNeg = 1;
    cycle();
    FlagWrEn = 0; AluNeg = 0;
    #2;
    checks++;
    if ({BranchRelEn, Forward, Target} !== {1'b1, 1'b0, 8'h03}) begin
      errors++;
      $display("FAIL blt_n1: got rel=%b fwd=%b tgt=%h want 1/0/03", BranchRelEn, Forward, Target);
    end
    BrOp = 3'b101;
    #1;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL bcs_c0: got %b want 0", BranchRelEn);
    end
  endtask

  task automatic test_zero_mag();
    LutWrEn = 1; LutWrAddr = 5; LutWrData = 9'h100; BrOp = 0;
    cycle();
    LutWrEn = 0; BrOp = 3'b001; LutIdx = 5;
    #2;
    checks++;
    if ({BranchRelEn, Target, Forward} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL zero_mag: got rel=%b tgt=%h fwd=%b want 0/00/1", BranchRelEn, Target, Forward);
    end
  endtask

  task automatic test_write_bypass();
    LutWrEn = 1; LutWrAddr = 3; LutWrData = 9'h0AA; BrOp = 3'b001; LutIdx = 3;
    #2;
    checks++;
    if ({Target, Forward} !== {8'h05, 1'b1}) begin
      errors++; $display("FAIL write_old_read: got tgt=%h fwd=%b want 05/1", Target, Forward);
    end
    cycle();
    LutWrEn = 0;
    #2;
    checks++;
    if ({BranchRelEn, Target, Forward} !== {1'b1, 8'hAA, 1'b0}) begin
      errors++;
      $display("FAIL write_new_read: got rel=%b tgt=%h fwd=%b want 1/aa/0", BranchRelEn, Target, Forward);
    end
  endtask

  task automatic test_halt();
    BrOp = 3'b110; LutIdx = 3;
    #2;
    checks++;
    if ({BranchRelEn, Done} !== 2'b00) begin
      errors++; $display("FAIL halt_cycle: got rel=%b done=%b want 0/0", BranchRelEn, Done);
    end
    cycle();
    BrOp = 3'b001;
    #2;
    checks++;
    if ({BranchRelEn, Done} !== 2'b01) begin
      errors++; $display("FAIL halted: got rel=%b done=%b want 0/1", BranchRelEn, Done);
    end
    Start = 1;
    cycle();
    Start = 0; Going = 0;
    #2;
    checks++;
    if ({BranchRelEn, Done, Flags} !== 5'b0) begin
      errors++;
      $display("FAIL start_from_halt: got rel=%b done=%b flags=%b want 0/0/000", BranchRelEn, Done, Flags);
    end
    Going = 1;
    #1;
    checks++;
    if (BranchRelEn !== 1'b0) begin
      errors++; $display("FAIL idle_after_halt: got %b want 0", BranchRelEn);
    end
    cycle();
    #2;
    checks++;
    if (BranchRelEn !== 1'b1) begin
      errors++; $display("FAIL rerun: got %b want 1", BranchRelEn);
    end
    Start = 1; BrOp = 3'b110;
    cycle();
    Start = 0; BrOp = 3'b001;
    #2;
    checks++;
    if ({BranchRelEn, Done} !== 2'b00) begin
      errors++; $display("FAIL start_over_halt: got rel=%b done=%b want 0/0", BranchRelEn, Done);
    end
    cycle();
  endtask

  task automatic test_reset_mid_run();
    FlagWrEn = 1; AluNeg = 1; AluCarry = 1; AluZero = 1; BrOp = 0;
    cycle();
    FlagWrEn = 0;
    #2;
    checks++;
    if (Flags !== 3'b111) begin
      errors++; $display("FAIL flags_all: got %b want 111", Flags);
    end
    Reset = 1; BrOp = 3'b001;
    cycle();
    #2;
    checks++;
    if ({BranchRelEn, Target, Forward, Flags, Done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got rel=%b tgt=%h fwd=%b flags=%b done=%b want all zero",
               BranchRelEn, Target, Forward, Flags, Done);
    end
    quiet();
  endtask

  task automatic test_random();
    logic [13:0] exp;
    for (int n = 0; n < 600; n++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      Start     = ($urandom_range(0, 19) == 0);
      Going     = ($urandom_range(0, 4) != 0);
      BrOp      = 3'($urandom_range(0, 7));
      LutIdx    = LW'($urandom_range(0, 15));
      FlagWrEn  = ($urandom_range(0, 2) == 0);
      AluZero   = 1'($urandom_range(0, 1));
      AluNeg    = 1'($urandom_range(0, 1));
      AluCarry  = 1'($urandom_range(0, 1));
      LutWrEn   = ($urandom_range(0, 2) == 0);
      LutWrAddr = LW'($urandom_range(0, 15));
      LutWrData = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) LutWrData[7:0] = 8'h00;
      #2;
      exp = {m_taken(), m_tab[LutIdx][TW-1:0], m_tab[LutIdx][TW], m_n, m_c, m_z, (m_st == 2)};
      checks++;
      if ({BranchRelEn, Target, Forward, Flags, Done} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got rel/tgt/fwd/flags/done=%h want %h", n,
                 {BranchRelEn, Target, Forward, Flags, Done}, exp);
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (TakenCount !== 16'(m_cnt)) begin
        errors++; $display("FAIL taken_count[%0d]: got %0d want %0d", n, TakenCount, m_cnt);
      end
`endif
      cycle();
    end
  endtask

  initial begin
    m_st = 0; m_n = 0; m_c = 0; m_z = 0; m_cnt = 0;
    for (int i = 0; i < 16; i++) m_tab[i] = '0;
    quiet();
    test_reset();
    test_run_entry();
    test_always();
    test_flag_timing();
    test_blt();
    test_zero_mag();
    test_write_bypass();
    test_halt();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
